// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory: MMIO map, ERR bit positions and the
// address-decode helper used by the data_mem top level.
package dmem_pkg;

  localparam logic [31:0] MMIO_BASE     = 32'h1000_0000;
  localparam logic [11:0] OFF_CYCLE_LO  = 12'h000;
  localparam logic [11:0] OFF_CYCLE_HI  = 12'h004;
  localparam logic [11:0] OFF_TOHOST    = 12'h008;
  localparam logic [11:0] OFF_LOADCNT   = 12'h00C;
  localparam logic [11:0] OFF_STORECNT  = 12'h010;
  localparam logic [11:0] OFF_ERR       = 12'h014;
  localparam logic [11:0] OFF_END       = 12'h018;

  localparam int ERR_MISAL_BIT = 0;
  localparam int ERR_UNMAP_BIT = 1;

  typedef enum logic [1:0] {
    SEL_RAM   = 2'd0,
    SEL_MMIO  = 2'd1,
    SEL_UNMAP = 2'd2,
    SEL_MISAL = 2'd3
  } mmio_sel_t;

  // Misalignment takes priority over every region check.
  function automatic mmio_sel_t decode_addr(input logic [31:0] addr,
                                            input logic [31:0] ram_bytes,
                                            input logic        mmio_en);
    mmio_sel_t sel;
    if (addr[1:0] != 2'b00) begin
      sel = SEL_MISAL;
    end else if (addr < ram_bytes) begin
      sel = SEL_RAM;
    end else if (mmio_en && (addr[31:12] == MMIO_BASE[31:12]) && (addr[11:0] < OFF_END)) begin
      sel = SEL_MMIO;
    end else begin
      sel = SEL_UNMAP;
    end
    return sel;
  endfunction

endpackage

// File: rtl/dmem_mmio.sv
// MMIO register block: cycle/load/store counters, CYCLE_HI shadow, TOHOST and
// sticky ERR. Only compiled when DMEM_MMIO_EN is defined.
`ifdef DMEM_MMIO_EN
module dmem_mmio
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        store,
  input  logic        hit,
  input  logic [11:0] offset,
  input  logic [31:0] wdata,
  input  logic [1:0]  err_set,
  output logic [31:0] rdata,
  output logic        halt,
  output logic [31:0] tohost,
  output logic [1:0]  err
);

  logic [63:0] cycle_r;
  logic [31:0] hi_shadow_r;
  logic [31:0] loadcnt_r;
  logic [31:0] storecnt_r;
  logic [31:0] tohost_r;
  logic        halt_r;
  logic [1:0]  err_r;
  logic [1:0]  err_clr_s;
  logic [1:0]  err_nxt_s;
  logic        rd_lo_s;
  logic        wr_tohost_s;

  assign rd_lo_s     = hit & load & (offset == OFF_CYCLE_LO);
  assign wr_tohost_s = hit & store & (offset == OFF_TOHOST) & ~halt_r;

  // Register read mux
  always_comb begin
    rdata = 32'd0;
    if (hit) begin
      case (offset)
        OFF_CYCLE_LO: rdata = cycle_r[31:0];
        OFF_CYCLE_HI: rdata = hi_shadow_r;
        OFF_TOHOST:   rdata = tohost_r;
        OFF_LOADCNT:  rdata = loadcnt_r;
        OFF_STORECNT: rdata = storecnt_r;
        OFF_ERR:      rdata = {30'd0, err_r};
        default:      rdata = 32'd0;
      endcase
    end else begin
      rdata = 32'd0;
    end
  end

  // ERR write-one-to-clear; a new error in the same cycle wins over the clear
  always_comb begin
    err_clr_s = 2'b00;
    if (hit && store && (offset == OFF_ERR)) begin
      err_clr_s = wdata[1:0];
    end else begin
      err_clr_s = 2'b00;
    end
    err_nxt_s = (err_r & ~err_clr_s) | err_set;
  end

  // Counters, shadow, TOHOST/halt and ERR state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_r     <= 64'd0;
      hi_shadow_r <= 32'd0;
      loadcnt_r   <= 32'd0;
      storecnt_r  <= 32'd0;
      tohost_r    <= 32'd0;
      halt_r      <= 1'b0;
      err_r       <= 2'b00;
    end else begin
      cycle_r    <= cycle_r + 64'd1;
      loadcnt_r  <= loadcnt_r + {31'd0, load};
      storecnt_r <= storecnt_r + {31'd0, store};
      if (rd_lo_s) begin
        hi_shadow_r <= cycle_r[63:32];
      end
      if (wr_tohost_s) begin
        tohost_r <= wdata;
        if (wdata != 32'd0) begin
          halt_r <= 1'b1;
        end
      end
      err_r <= err_nxt_s;
    end
  end

  assign halt   = halt_r;
  assign tohost = tohost_r;
  assign err    = err_r;

endmodule
`endif

// File: rtl/data_mem.sv
// Word-addressed data memory for the core's data port: RAM plus an optional
// MMIO window enabled by the DMEM_MMIO_EN macro.
module data_mem #(
  parameter int    DEPTH     = 1024,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_ce_i,
  input  logic        data_we_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        halt_o,
  output logic [31:0] tohost_o,
  output logic        err_o
);

  import dmem_pkg::*;

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);
`ifdef DMEM_MMIO_EN
  localparam logic        MMIO_EN   = 1'b1;
`else
  localparam logic        MMIO_EN   = 1'b0;
`endif

  logic [31:0]   mem_r [DEPTH];
  mmio_sel_t     sel_s;
  logic [AW-1:0] ram_idx_s;
  logic          load_s;
  logic          store_s;
  logic [1:0]    err_set_s;
  logic [31:0]   mmio_rdata_s;
  logic [1:0]    err_s;

  assign sel_s     = decode_addr(data_addr_i, RAM_BYTES, MMIO_EN);
  assign ram_idx_s = data_addr_i[AW+1:2];
  assign load_s    = data_ce_i & ~data_we_i;
  assign store_s   = data_ce_i & data_we_i;

  // Error causes raised by the current access
  always_comb begin
    err_set_s = 2'b00;
    if (data_ce_i) begin
      case (sel_s)
        SEL_MISAL: err_set_s[ERR_MISAL_BIT] = 1'b1;
        SEL_UNMAP: err_set_s[ERR_UNMAP_BIT] = 1'b1;
        default:   err_set_s = 2'b00;
      endcase
    end else begin
      err_set_s = 2'b00;
    end
  end

  // RAM write port; contents intentionally survive reset
  always_ff @(posedge clk) begin
    if (store_s && (sel_s == SEL_RAM)) begin
      mem_r[ram_idx_s] <= data_i;
    end
  end

  // Zero-latency load mux
  always_comb begin
    data_o = 32'd0;
    if (load_s) begin
      case (sel_s)
        SEL_RAM:  data_o = mem_r[ram_idx_s];
        SEL_MMIO: data_o = mmio_rdata_s;
        default:  data_o = 32'd0;
      endcase
    end else begin
      data_o = 32'd0;
    end
  end

`ifdef DMEM_MMIO_EN
  dmem_mmio u_mmio (
    .clk     (clk),
    .rst     (rst),
    .load    (load_s),
    .store   (store_s),
    .hit     (sel_s == SEL_MMIO),
    .offset  (data_addr_i[11:0]),
    .wdata   (data_i),
    .err_set (err_set_s),
    .rdata   (mmio_rdata_s),
    .halt    (halt_o),
    .tohost  (tohost_o),
    .err     (err_s)
  );
`else
  logic [1:0] err_r;

  // Without the window ERR is sticky until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 2'b00;
    end else begin
      err_r <= err_r | err_set_s;
    end
  end

  assign err_s        = err_r;
  assign mmio_rdata_s = 32'd0;
  assign halt_o       = 1'b0;
  assign tohost_o     = 32'd0;
`endif

  assign err_o = err_s[ERR_UNMAP_BIT] | err_s[ERR_MISAL_BIT];

endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem; MMIO checks are compiled only
// when DMEM_MMIO_EN is defined, otherwise the window is checked as unmapped.
module tb_data_mem;

  localparam logic [31:0] A_CYC_LO = 32'h1000_0000;
  localparam logic [31:0] A_CYC_HI = 32'h1000_0004;
  localparam logic [31:0] A_TOHOST = 32'h1000_0008;
  localparam logic [31:0] A_LDCNT  = 32'h1000_000C;
  localparam logic [31:0] A_STCNT  = 32'h1000_0010;
  localparam logic [31:0] A_ERR    = 32'h1000_0014;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        halt;
  logic [31:0] tohost;
  logic        err;
  logic [31:0] rd;
  int          n_checks;
  int          n_fail;

  data_mem dut (
    .clk         (clk),
    .rst         (rst),
    .data_ce_i   (ce),
    .data_we_i   (we),
    .data_addr_i (addr),
    .data_i      (wdata),
    .data_o      (rdata),
    .halt_o      (halt),
    .tohost_o    (tohost),
    .err_o       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // One access cycle starting at a negedge; rd is data_o sampled mid-cycle.
  task automatic cyc(input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] r);
    ce = 1'b1; we = w; addr = a; wdata = d;
    #1;
    r = rdata;
    @(negedge clk);
    ce = 1'b0; we = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; ce = 1'b0; we = 1'b0; addr = 32'h0000_0040; wdata = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_data", rdata, 32'd0);
    check("rst_halt", {31'd0, halt}, 32'd0);
    check("rst_tohost", tohost, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // RAM store/load
    cyc(1'b1, 32'h0000_0040, 32'h1111_1111, rd);
    cyc(1'b0, 32'h0000_0040, 32'd0, rd);        check("ram_first", rd, 32'h1111_1111);
    cyc(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, rd);
    cyc(1'b0, 32'h0000_0040, 32'd0, rd);        check("ram_40", rd, 32'hDEAD_BEEF);
    cyc(1'b1, 32'h0000_0044, 32'h1234_5678, rd);
    cyc(1'b0, 32'h0000_0040, 32'd0, rd);        check("ram_40_keep", rd, 32'hDEAD_BEEF);
    cyc(1'b0, 32'h0000_0044, 32'd0, rd);        check("ram_44", rd, 32'h1234_5678);
    cyc(1'b1, 32'h0000_0FFC, 32'hA5A5_A5A5, rd);
    cyc(1'b0, 32'h0000_0FFC, 32'd0, rd);        check("ram_last", rd, 32'hA5A5_A5A5);
    check("err_clean", {31'd0, err}, 32'd0);
    addr = 32'h0000_0040; #1;
    check("ce0_data", rdata, 32'd0);
    @(negedge clk);

    // Misaligned store is dropped and flagged
    cyc(1'b1, 32'h0000_0042, 32'hCAFE_F00D, rd);
    check("misal_err", {31'd0, err}, 32'd1);
    cyc(1'b0, 32'h0000_0040, 32'd0, rd);        check("misal_ram", rd, 32'hDEAD_BEEF);
    cyc(1'b0, 32'h0000_0042, 32'd0, rd);        check("misal_load", rd, 32'd0);
    cyc(1'b0, 32'h0000_1000, 32'd0, rd);        check("ram_end_unmap", rd, 32'd0);

`ifdef DMEM_MMIO_EN
    cyc(1'b0, A_ERR, 32'd0, rd);                check("err_reg_3", rd, 32'h3);
    cyc(1'b1, A_ERR, 32'h1, rd);
    cyc(1'b0, A_ERR, 32'd0, rd);                check("err_w1c_b0", rd, 32'h2);
    check("err_o_b1", {31'd0, err}, 32'd1);
    cyc(1'b1, A_ERR, 32'h2, rd);
    check("err_o_clr", {31'd0, err}, 32'd0);

    // TOHOST / halt
    cyc(1'b1, A_TOHOST, 32'h0, rd);
    check("tohost0_halt", {31'd0, halt}, 32'd0);
    cyc(1'b1, A_TOHOST, 32'h1, rd);
    check("tohost1_halt", {31'd0, halt}, 32'd1);
    check("tohost1_val", tohost, 32'h1);
    cyc(1'b1, A_TOHOST, 32'h5, rd);
    check("tohost_locked", tohost, 32'h1);
    cyc(1'b0, A_TOHOST, 32'd0, rd);             check("tohost_read", rd, 32'h1);

    // Unmapped offset and misaligned MMIO
    cyc(1'b0, 32'h1000_0018, 32'd0, rd);        check("mmio_unmap_load", rd, 32'd0);
    cyc(1'b0, A_ERR, 32'd0, rd);                check("mmio_unmap_err", rd, 32'h2);
    cyc(1'b1, A_ERR, 32'h3, rd);
    cyc(1'b0, 32'h1000_0006, 32'd0, rd);        check("mmio_misal_load", rd, 32'd0);
    cyc(1'b0, A_ERR, 32'd0, rd);                check("mmio_misal_err", rd, 32'h1);

    // CYCLE_LO read on the 32-bit wrap edge
    force dut.u_mmio.cycle_r = 64'h0000_0000_FFFF_FFFF;
    ce = 1'b1; we = 1'b0; addr = A_CYC_LO;
    #1;
    release dut.u_mmio.cycle_r;
    rd = rdata;
    @(negedge clk);
    ce = 1'b0;
    check("wrap_lo", rd, 32'hFFFF_FFFF);
    cyc(1'b0, A_CYC_HI, 32'd0, rd);             check("wrap_hi", rd, 32'h0);
    cyc(1'b0, A_CYC_LO, 32'd0, rd);             check("post_wrap_lo", rd, 32'h1);
    cyc(1'b0, A_CYC_HI, 32'd0, rd);             check("post_wrap_hi", rd, 32'h1);
`else
    cyc(1'b1, A_ERR, 32'h3, rd);
    check("err_no_clear", {31'd0, err}, 32'd1);
    cyc(1'b0, A_ERR, 32'd0, rd);                check("nommio_err_load", rd, 32'd0);
`endif

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    check("mid_rst_halt", {31'd0, halt}, 32'd0);
    check("mid_rst_tohost", tohost, 32'd0);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    check("mid_rst_data", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // RAM survives reset; five loads then three stores from cycle 0
    cyc(1'b0, 32'h0000_0040, 32'd0, rd);        check("post_rst_40", rd, 32'hDEAD_BEEF);
    cyc(1'b0, 32'h0000_0044, 32'd0, rd);        check("post_rst_44", rd, 32'h1234_5678);
    cyc(1'b0, 32'h0000_0FFC, 32'd0, rd);        check("post_rst_last", rd, 32'hA5A5_A5A5);
    cyc(1'b0, 32'h0000_0040, 32'd0, rd);
    cyc(1'b0, 32'h0000_0044, 32'd0, rd);
    cyc(1'b1, 32'h0000_0048, 32'h0BAD_F00D, rd);
    cyc(1'b1, 32'h0000_004C, 32'h0000_0001, rd);
    cyc(1'b1, 32'h0000_0050, 32'h8000_0000, rd);

`ifdef DMEM_MMIO_EN
    cyc(1'b0, A_LDCNT, 32'd0, rd);              check("loadcnt", rd, 32'd5);
    cyc(1'b0, A_STCNT, 32'd0, rd);              check("storecnt", rd, 32'd3);
    cyc(1'b0, A_CYC_LO, 32'd0, rd);             check("cycle_10", rd, 32'd10);
    cyc(1'b0, 32'h0000_0048, 32'd0, rd);        check("ram_48", rd, 32'h0BAD_F00D);
    cyc(1'b1, A_LDCNT, 32'h0000_FFFF, rd);
    cyc(1'b0, A_LDCNT, 32'd0, rd);              check("loadcnt_ro", rd, 32'd9);
    check("post_rst_err_clean", {31'd0, err}, 32'd0);
`else
    cyc(1'b0, 32'h0000_0050, 32'd0, rd);        check("ram_50", rd, 32'h8000_0000);
    check("post_rst_err_clean", {31'd0, err}, 32'd0);
    cyc(1'b0, A_CYC_LO, 32'd0, rd);             check("nommio_load", rd, 32'd0);
    check("nommio_err", {31'd0, err}, 32'd1);
    cyc(1'b1, A_TOHOST, 32'h1, rd);
    check("nommio_halt", {31'd0, halt}, 32'd0);
    check("nommio_tohost", tohost, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
